// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU, step and control-bit definitions for the single-bus CPU
package cpu_pkg;

   localparam int OPCODE_W = 5;

   localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10100;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

   // ALU codes reuse the register-form opcodes so R-type instructions pass straight through
   typedef enum logic [4:0] {
      ALU_NONE = 5'b00000,
      ALU_ADD  = 5'b00011,
      ALU_SUB  = 5'b00100,
      ALU_AND  = 5'b00101,
      ALU_OR   = 5'b00110
   } alu_op_e;

   typedef logic [3:0] step_t;
   localparam step_t S_RESET = 4'd0;
   localparam step_t S_T0    = 4'd1;
   localparam step_t S_T1    = 4'd2;
   localparam step_t S_T2    = 4'd3;
   localparam step_t S_T3    = 4'd4;
   localparam step_t S_T4    = 4'd5;
   localparam step_t S_T5    = 4'd6;
   localparam step_t S_T6    = 4'd7;
   localparam step_t S_T7    = 4'd8;
   localparam step_t S_HALT  = 4'd9;

   localparam int SEL_GRA   = 5;
   localparam int SEL_GRB   = 4;
   localparam int SEL_GRC   = 3;
   localparam int SEL_RIN   = 2;
   localparam int SEL_ROUT  = 1;
   localparam int SEL_BAOUT = 0;

   localparam int BUS_C     = 3;
   localparam int BUS_ZLOW  = 2;
   localparam int BUS_MDR   = 1;
   localparam int BUS_PC    = 0;

   localparam int LD_CON    = 6;
   localparam int LD_IR     = 5;
   localparam int LD_Y      = 4;
   localparam int LD_Z      = 3;
   localparam int LD_MAR    = 2;
   localparam int LD_MDR    = 1;
   localparam int LD_PC     = 0;

   localparam int MEM_RSEL  = 2;
   localparam int MEM_WR    = 1;
   localparam int MEM_RD    = 0;

   typedef struct packed {
      logic [5:0] sel;
      logic [3:0] bus;
      logic [6:0] ld;
      logic [2:0] mem;
      logic       inc;
      alu_op_e    alu;
   } ctl_t;

   function automatic logic is_rtype(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic is_itype(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   function automatic alu_op_e alu_of(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - cycle counter for a memory wait step with timeout compare
module mem_wait_timer #(
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_i,
   input  logic ready_i,
   input  logic clear_i,
   output logic timeout_o
);

   localparam int CW = $clog2(MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q is the number of unanswered cycles already spent in the current wait step
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !wait_i) begin
         cnt_d = '0;
      end else if (!ready_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = wait_i && !ready_i && (cnt_q == CW'(MAX - 1));

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - control-step sequencer: fetch, decode and per-step datapath strobes
module ctrl_seq
   import cpu_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int OP_W         = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        mem_ready,
   output logic [5:0]  sel_ctl,
   output logic [3:0]  bus_src,
   output logic [6:0]  ld_en,
   output logic [2:0]  mem_ctl,
   output logic        inc_pc,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        mem_err
);

   logic [OP_W-1:0] op;
   logic            ir_unused;
   step_t           step_q, step_d;
   logic            mem_err_q, mem_err_d;
   logic            wait_step, timeout, step_change;
   logic            is_r, is_i, is_alu, is_addr, is_mem;
   ctl_t            ctl;

   assign op        = ir[31 -: OP_W];
   assign ir_unused = ^ir[31-OP_W:0];

   assign is_r    = is_rtype(op);
   assign is_i    = is_itype(op);
   assign is_alu  = is_r || is_i;
   assign is_mem  = (op == OP_LD) || (op == OP_ST);
   assign is_addr = is_mem || (op == OP_LDI);

   assign wait_step = (step_q == S_T1) ||
                      ((step_q == S_T6) && (op == OP_LD)) ||
                      ((step_q == S_T7) && (op == OP_ST));

   mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
      .clk       (clk),
      .rst       (reset),
      .wait_i    (wait_step),
      .ready_i   (mem_ready),
      .clear_i   (step_change),
      .timeout_o (timeout)
   );

   always_comb begin
      step_d    = step_q;
      mem_err_d = mem_err_q;
      case (step_q)
         S_RESET: step_d = S_T0;
         S_T0:    step_d = S_T1;
         S_T1:    if (mem_ready) step_d = S_T2;
         S_T2: begin
            if (op == OP_HALT) begin
               step_d = S_HALT;
            end else if (op == OP_NOP) begin
               step_d = S_T0;
            end else if (is_alu || is_addr || (op == OP_BR) || (op == OP_JR)) begin
               step_d = S_T3;
            end else begin
               step_d = S_T0;
            end
         end
         S_T3:    step_d = (op == OP_JR) ? S_T0 : S_T4;
         S_T4:    step_d = S_T5;
         S_T5:    step_d = (is_mem || (op == OP_BR)) ? S_T6 : S_T0;
         S_T6: begin
            if (op == OP_LD) begin
               if (mem_ready) step_d = S_T7;
            end else if (op == OP_ST) begin
               step_d = S_T7;
            end else begin
               step_d = S_T0;
            end
         end
         S_T7:    if ((op != OP_ST) || mem_ready) step_d = S_T0;
         S_HALT:  step_d = S_HALT;
         default: step_d = S_RESET;
      endcase
      if (timeout) begin
         step_d    = S_HALT;
         mem_err_d = 1'b1;
      end
   end

   assign step_change = (step_d != step_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q    <= S_RESET;
         mem_err_q <= 1'b0;
      end else begin
         step_q    <= step_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Moore decode: a wait step repeats these values unchanged until it completes
   always_comb begin
      ctl     = '0;
      ctl.alu = ALU_NONE;
      case (step_q)
         S_T0: begin
            ctl.bus[BUS_PC] = 1'b1;
            ctl.ld[LD_MAR]  = 1'b1;
            ctl.ld[LD_Z]    = 1'b1;
            ctl.inc         = 1'b1;
         end
         S_T1: begin
            ctl.bus[BUS_ZLOW]  = 1'b1;
            ctl.ld[LD_PC]      = 1'b1;
            ctl.ld[LD_MDR]     = 1'b1;
            ctl.mem[MEM_RSEL]  = 1'b1;
            ctl.mem[MEM_RD]    = 1'b1;
         end
         S_T2: begin
            ctl.bus[BUS_MDR] = 1'b1;
            ctl.ld[LD_IR]    = 1'b1;
         end
         S_T3: begin
            if (is_alu) begin
               ctl.sel[SEL_GRB]  = 1'b1;
               ctl.sel[SEL_ROUT] = 1'b1;
               ctl.ld[LD_Y]      = 1'b1;
            end else if (is_addr) begin
               ctl.sel[SEL_GRB]   = 1'b1;
               ctl.sel[SEL_BAOUT] = 1'b1;
               ctl.ld[LD_Y]       = 1'b1;
            end else if ((op == OP_BR) || (op == OP_JR)) begin
               ctl.sel[SEL_GRA]  = 1'b1;
               ctl.sel[SEL_ROUT] = 1'b1;
               ctl.ld[LD_CON]    = (op == OP_BR);
               ctl.ld[LD_PC]     = (op == OP_JR);
            end
         end
         S_T4: begin
            if (is_r) begin
               ctl.sel[SEL_GRC]  = 1'b1;
               ctl.sel[SEL_ROUT] = 1'b1;
               ctl.alu           = alu_of(op);
               ctl.ld[LD_Z]      = 1'b1;
            end else if (is_i || is_addr) begin
               ctl.bus[BUS_C] = 1'b1;
               ctl.alu        = is_i ? alu_of(op) : ALU_ADD;
               ctl.ld[LD_Z]   = 1'b1;
            end else if (op == OP_BR) begin
               ctl.bus[BUS_PC] = 1'b1;
               ctl.ld[LD_Y]    = 1'b1;
            end
         end
         S_T5: begin
            if (is_alu || (op == OP_LDI)) begin
               ctl.bus[BUS_ZLOW] = 1'b1;
               ctl.sel[SEL_GRA]  = 1'b1;
               ctl.sel[SEL_RIN]  = 1'b1;
            end else if (is_mem) begin
               ctl.bus[BUS_ZLOW] = 1'b1;
               ctl.ld[LD_MAR]    = 1'b1;
            end else if (op == OP_BR) begin
               ctl.bus[BUS_C] = 1'b1;
               ctl.alu        = ALU_ADD;
               ctl.ld[LD_Z]   = 1'b1;
            end
         end
         S_T6: begin
            if (op == OP_LD) begin
               ctl.mem[MEM_RSEL] = 1'b1;
               ctl.mem[MEM_RD]   = 1'b1;
               ctl.ld[LD_MDR]    = 1'b1;
            end else if (op == OP_ST) begin
               ctl.sel[SEL_GRA]  = 1'b1;
               ctl.sel[SEL_ROUT] = 1'b1;
               ctl.ld[LD_MDR]    = 1'b1;
            end else if (op == OP_BR) begin
               ctl.bus[BUS_ZLOW] = 1'b1;
               ctl.ld[LD_PC]     = con_ff;
            end
         end
         S_T7: begin
            if (op == OP_LD) begin
               ctl.bus[BUS_MDR] = 1'b1;
               ctl.sel[SEL_GRA] = 1'b1;
               ctl.sel[SEL_RIN] = 1'b1;
            end else if (op == OP_ST) begin
               ctl.mem[MEM_WR] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign sel_ctl = ctl.sel;
   assign bus_src = ctl.bus;
   assign ld_en   = ctl.ld;
   assign mem_ctl = ctl.mem;
   assign inc_pc  = ctl.inc;
   assign alu_op  = ctl.alu;
   assign run     = (step_q != S_RESET) && (step_q != S_HALT);
   assign mem_err = mem_err_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - randomized self-checking bench for ctrl_seq against a step-plan reference model
module tb_ctrl_seq;

   localparam int MAXW = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        con_ff = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] ir = 32'h0;
   logic [5:0]  sel_ctl;
   logic [3:0]  bus_src;
   logic [6:0]  ld_en;
   logic [2:0]  mem_ctl;
   logic        inc_pc;
   logic [4:0]  alu_op;
   logic        run;
   logic        mem_err;

   ctrl_seq #(.MEM_WAIT_MAX(MAXW), .OP_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .ir        (ir),
      .con_ff    (con_ff),
      .mem_ready (mem_ready),
      .sel_ctl   (sel_ctl),
      .bus_src   (bus_src),
      .ld_en     (ld_en),
      .mem_ctl   (mem_ctl),
      .inc_pc    (inc_pc),
      .alu_op    (alu_op),
      .run       (run),
      .mem_err   (mem_err)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] GRA = 6'd32, GRB = 6'd16, GRC = 6'd8, RIN = 6'd4, ROUT = 6'd2, BAOUT = 6'd1;
   localparam logic [3:0] COUT = 4'd8, ZLOW = 4'd4, MDRO = 4'd2, PCO = 4'd1;
   localparam logic [6:0] CONIN = 7'd64, IRIN = 7'd32, YIN = 7'd16, ZIN = 7'd8, MARIN = 7'd4, MDRIN = 7'd2, PCIN = 7'd1;
   localparam logic [2:0] RSEL = 3'd4, WR = 3'd2, RD = 3'd1;
   localparam logic [4:0] A_ADD = 5'b00011, A_AND = 5'b00101, A_OR = 5'b00110;

   typedef struct packed {
      bit         w;
      logic [5:0] sel;
      logic [3:0] bus;
      logic [6:0] ld;
      logic [2:0] mem;
      logic       inc;
      logic [4:0] alu;
   } stp_t;

   int          n_chk = 0;
   int          n_fail = 0;
   stp_t        plan[$];
   int          m_mode = 0;
   int          pi = 0;
   int          waited = 0;
   logic        exp_err = 1'b0;
   bit          need_new = 1'b0;
   logic [4:0]  cur_op = 5'd0;
   bit          use_ir = 1'b0;
   logic [31:0] fix_ir = 32'h0;
   int          fix_cf = -1;
   int          rdy_mode = 1;
   int          rdy_delay = 0;
   int          hcnt = 0;
   logic [4:0]  optab[14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                              5'd12, 5'd13, 5'd14, 5'd18, 5'd20, 5'd26, 5'd27};

   wire [27:0] dut_vec = {sel_ctl, bus_src, ld_en, mem_ctl, inc_pc, alu_op, run, mem_err};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic stp_t mk(bit w, logic [5:0] s, logic [3:0] b, logic [6:0] l,
                               logic [2:0] m, logic inc, logic [4:0] a);
      stp_t r;
      r.w = w; r.sel = s; r.bus = b; r.ld = l; r.mem = m; r.inc = inc; r.alu = a;
      return r;
   endfunction

   // Whole-instruction list of expected step outputs, T0 first
   task automatic build_plan(input logic [4:0] op, input logic cf);
      logic [4:0] ia;
      plan.delete();
      plan.push_back(mk(0, 6'd0, PCO, MARIN | ZIN, 3'd0, 1'b1, 5'd0));
      plan.push_back(mk(1, 6'd0, ZLOW, PCIN | MDRIN, RSEL | RD, 1'b0, 5'd0));
      plan.push_back(mk(0, 6'd0, MDRO, IRIN, 3'd0, 1'b0, 5'd0));
      ia = (op == 5'd12) ? A_ADD : (op == 5'd13) ? A_AND : A_OR;
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6: begin
            plan.push_back(mk(0, GRB | ROUT, 4'd0, YIN, 3'd0, 1'b0, 5'd0));
            plan.push_back(mk(0, GRC | ROUT, 4'd0, ZIN, 3'd0, 1'b0, op));
            plan.push_back(mk(0, GRA | RIN, ZLOW, 7'd0, 3'd0, 1'b0, 5'd0));
         end
         5'd12, 5'd13, 5'd14: begin
            plan.push_back(mk(0, GRB | ROUT, 4'd0, YIN, 3'd0, 1'b0, 5'd0));
            plan.push_back(mk(0, 6'd0, COUT, ZIN, 3'd0, 1'b0, ia));
            plan.push_back(mk(0, GRA | RIN, ZLOW, 7'd0, 3'd0, 1'b0, 5'd0));
         end
         5'd0, 5'd1, 5'd2: begin
            plan.push_back(mk(0, GRB | BAOUT, 4'd0, YIN, 3'd0, 1'b0, 5'd0));
            plan.push_back(mk(0, 6'd0, COUT, ZIN, 3'd0, 1'b0, A_ADD));
            if (op == 5'd1) begin
               plan.push_back(mk(0, GRA | RIN, ZLOW, 7'd0, 3'd0, 1'b0, 5'd0));
            end else begin
               plan.push_back(mk(0, 6'd0, ZLOW, MARIN, 3'd0, 1'b0, 5'd0));
               if (op == 5'd0) begin
                  plan.push_back(mk(1, 6'd0, 4'd0, MDRIN, RSEL | RD, 1'b0, 5'd0));
                  plan.push_back(mk(0, GRA | RIN, MDRO, 7'd0, 3'd0, 1'b0, 5'd0));
               end else begin
                  plan.push_back(mk(0, GRA | ROUT, 4'd0, MDRIN, 3'd0, 1'b0, 5'd0));
                  plan.push_back(mk(1, 6'd0, 4'd0, 7'd0, WR, 1'b0, 5'd0));
               end
            end
         end
         5'd18: begin
            plan.push_back(mk(0, GRA | ROUT, 4'd0, CONIN, 3'd0, 1'b0, 5'd0));
            plan.push_back(mk(0, 6'd0, PCO, YIN, 3'd0, 1'b0, 5'd0));
            plan.push_back(mk(0, 6'd0, COUT, ZIN, 3'd0, 1'b0, A_ADD));
            plan.push_back(mk(0, 6'd0, ZLOW, cf ? PCIN : 7'd0, 3'd0, 1'b0, 5'd0));
         end
         5'd20: plan.push_back(mk(0, GRA | ROUT, 4'd0, PCIN, 3'd0, 1'b0, 5'd0));
         default: ;
      endcase
   endtask

   task automatic pick_instr();
      logic [31:0] r;
      logic [4:0]  op;
      r = $urandom();
      if (use_ir) begin
         ir = fix_ir;
      end else begin
         op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : optab[$urandom_range(0, 13)];
         ir = {op, r[26:0]};
      end
      con_ff = (fix_cf >= 0) ? fix_cf[0] : 1'($urandom_range(0, 1));
      cur_op = ir[31:27];
      build_plan(cur_op, con_ff);
   endtask

   function automatic logic [27:0] exp_vec();
      stp_t s;
      if (m_mode == 1) begin
         s = plan[pi];
         return {s.sel, s.bus, s.ld, s.mem, s.inc, s.alu, 1'b1, exp_err};
      end
      return {27'd0, exp_err};
   endfunction

   task automatic cycle();
      bit in_wait;
      @(negedge clk);
      if (m_mode == 1 && need_new) begin
         pick_instr();
         need_new = 1'b0;
      end
      in_wait = (m_mode == 1) && plan[pi].w;
      case (rdy_mode)
         0:       mem_ready = ($urandom_range(0, 3) != 0);
         1:       mem_ready = !(in_wait && pi != 1 && waited < rdy_delay);
         default: mem_ready = 1'b0;
      endcase
      #1;
      check("outs", 32'(dut_vec), 32'(exp_vec()));
      check("bus_onehot0", 32'($onehot0(bus_src)), 32'd1);
      check("gr_exclusive", 32'($onehot0(sel_ctl[5:3])), 32'd1);
      if (m_mode == 0) begin
         if (!reset) begin
            m_mode = 1; pi = 0; waited = 0; need_new = 1'b1;
         end
      end else if (m_mode == 1) begin
         if (in_wait && !mem_ready) begin
            waited++;
            if (waited == MAXW) begin
               m_mode = 2;
               exp_err = 1'b1;
            end
         end else begin
            waited = 0;
            pi++;
            if (pi == plan.size()) begin
               if (cur_op == 5'd27) begin
                  m_mode = 2;
               end else begin
                  pi = 0;
                  need_new = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b1;
      #1;
      check("rst_async", 32'(dut_vec), 32'd0);
      m_mode = 0; exp_err = 1'b0; waited = 0; need_new = 1'b0;
      repeat (hold) cycle();
      reset = 1'b0;
      m_mode = 1; pi = 0; waited = 0; need_new = 1'b1;
   endtask

   task automatic run_to(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_mode == 1 && !need_new && pi == k) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
      check("reach_step", 32'(ok), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #2;
      do_reset(2);

      use_ir = 1'b1; fix_cf = 0; rdy_mode = 1; rdy_delay = 0;
      fix_ir = 32'h18918000;
      repeat (6) cycle();

      fix_ir = {5'b00000, 4'd1, 4'd2, 19'h00010};
      rdy_delay = 3;
      repeat (11) cycle();

      fix_ir = {5'b10010, 4'd3, 4'd0, 19'h00020};
      fix_cf = 0;
      repeat (7) cycle();
      fix_cf = 1;
      repeat (7) cycle();

      fix_ir = 32'hD8000000;
      repeat (23) cycle();
      check("halt_run", 32'(run), 32'd0);
      do_reset(2);

      rdy_mode = 2;
      repeat (MAXW + 8) cycle();
      check("err_sticky", 32'(mem_err), 32'd1);
      do_reset(1);

      rdy_mode = 1; rdy_delay = 100;
      fix_ir = {5'b00010, 4'd5, 4'd6, 19'h00040};
      run_to(6);
      @(posedge clk); #2;
      check("pre_rst_t6", 32'(dut_vec), 32'(exp_vec()));
      do_reset(1);
      run_to(7);
      @(posedge clk); #2;
      check("pre_rst_t7", 32'(dut_vec), 32'(exp_vec()));
      do_reset(1);

      use_ir = 1'b0; fix_cf = -1; rdy_mode = 0;
      for (int i = 0; i < 4000; i++) begin
         cycle();
         if (m_mode == 2) begin
            hcnt++;
            if (hcnt > 3) begin
               do_reset(1);
               hcnt = 0;
            end
         end else if ($urandom_range(0, 299) == 0) begin
            do_reset($urandom_range(1, 2));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
